imrl_step_sequencer: RTL and testbench



---
 rtl/imrl_step_sequencer.sv | 130 +++++++++++++
 tb/tb_imrl_step_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imrl_step_sequencer.sv
// Thermometer stimulus sequencer for circuit2: drives IMRL 0000..1111, samples E per step.
// Define IMRL_SEQ_LOOP_EN to re-run the sequence continuously until abort or reset.
module imrl_step_sequencer #(
  parameter int STEP_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       e_in,
  output logic       i_out,
  output logic       m_out,
  output logic       r_out,
  output logic       l_out,
  output logic [2:0] step,
  output logic       busy,
  output logic       done,
  output logic [4:0] result,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [2:0] LP_STEP_MAX = 3'd4;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_step;
  logic [3:0] r_pat;
  logic       r_busy;
  logic       r_done;
  logic [4:0] r_result;
  logic       r_valid;
  logic [2:0] w_step_nxt;

  // {I,M,R,L} thermometer code for step k
  function automatic logic [3:0] therm(input logic [2:0] k);
    therm = {k >= 3'd4, k >= 3'd3, k >= 3'd2, k >= 3'd1};
  endfunction

  assign w_step_nxt = r_step + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_step   <= '0;
      r_pat    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_DRIVE;
            r_step   <= '0;
            r_cnt    <= '0;
            r_pat    <= '0;
            r_busy   <= 1'b1;
            r_result <= '0;
            r_valid  <= 1'b0;
          end
        end
        S_DRIVE: begin
          // abort beats the final sample: nothing is captured
          if (abort) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LP_LAST) begin
            r_result[r_step] <= e_in;
            r_cnt            <= '0;
            if (r_step == LP_STEP_MAX) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
            end else begin
              r_step <= w_step_nxt;
              r_pat  <= therm(w_step_nxt);
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
`ifdef IMRL_SEQ_LOOP_EN
          r_state <= S_DRIVE;
          r_step  <= '0;
          r_cnt   <= '0;
          r_pat   <= '0;
`else
          r_state <= S_IDLE;
          r_step  <= '0;
          r_cnt   <= '0;
          r_pat   <= '0;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= '0;
          r_cnt   <= '0;
          r_pat   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign i_out        = r_pat[3];
  assign m_out        = r_pat[2];
  assign r_out        = r_pat[1];
  assign l_out        = r_pat[0];
  assign step         = r_step;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_imrl_step_sequencer.sv
// Self-checking bench for imrl_step_sequencer (one-shot build, STEP_CYCLES=4).
// Expected outputs come from a timeline model indexed by cycles since start.
module tb_imrl_step_sequencer;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       e_in;
  logic       i_out, m_out, r_out, l_out;
  logic [2:0] step;
  logic       busy;
  logic       done;
  logic [4:0] result;
  logic       result_valid;

  int   mode;
  logic rnd_e;
  int   checks;
  int   errors;

  typedef struct {
    int         mode;
    int         abort_n;
    bit         spam;
    bit         sa;
    bit         chk;
    logic [4:0] res;
  } vec_t;

  vec_t tab[10];

  imrl_step_sequencer #(.STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .e_in(e_in),
    .i_out(i_out), .m_out(m_out), .r_out(r_out), .l_out(l_out),
    .step(step), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    e_in = 1'b0;
    case (mode)
      0: e_in = l_out;
      1: e_in = i_out & m_out & r_out & l_out;
      3: e_in = rnd_e;
      default: e_in = 1'b0;
    endcase
  end

  function automatic logic [14:0] pack_dut();
    return {step, busy, done, result_valid,
            i_out, m_out, r_out, l_out, result};
  endfunction

  task automatic check(input string name, input logic [14:0] act,
                       input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_seq(input vec_t v);
    logic [4:0]  mres;
    logic [3:0]  pat;
    logic [14:0] exp;
    logic        e;
    bit          ab_live;
    bit          aborted;
    int          last, lim, k;
    mres    = '0;
    mode    = v.mode;
    ab_live = (v.abort_n >= 0) && (v.abort_n < 5 * S);
    last    = ab_live ? v.abort_n + 2 : 5 * S + 2;
    lim     = ab_live ? v.abort_n : 5 * S;
    @(negedge clk);
    start = 1'b1;
    abort = v.sa;
    @(posedge clk);
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      aborted = ab_live && (n > v.abort_n);
      pat = 4'b0000;
      k = 0;
      if (aborted || n > 5 * S) begin
        exp = {3'd0, 1'b0, 1'b0, !aborted, 4'b0000, mres};
      end else if (n == 5 * S) begin
        pat = 4'b1111;
        exp = {3'd4, 1'b1, 1'b1, 1'b1, pat, mres};
      end else begin
        k = n / S;
        for (int j = 0; j < 4; j++) pat[j] = (k >= j + 1);
        exp = {3'(k), 1'b1, 1'b0, 1'b0, pat, mres};
      end
      check("cyc", pack_dut(), exp);
      start = (v.spam && n <= lim) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (n == v.abort_n);
      rnd_e = 1'($urandom_range(0, 1));
      case (v.mode)
        0: e = pat[0];
        1: e = &pat;
        3: e = rnd_e;
        default: e = 1'b0;
      endcase
      if (!aborted && n < 5 * S && (n % S) == S - 1 && n != v.abort_n)
        mres[n / S] = e;
    end
    start = 1'b0;
    abort = 1'b0;
    if (v.chk) check("result", {10'd0, result}, {10'd0, v.res});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode   = 2;
    rnd_e  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    rst    = 1'b1;

    tab[0] = '{0, -1,  0, 0, 1, 5'b11110};
    tab[1] = '{1, -1,  0, 0, 1, 5'b10000};
    tab[2] = '{2, -1,  0, 0, 1, 5'b00000};
    tab[3] = '{3, -1,  0, 0, 0, 5'b00000};
    tab[4] = '{0, 2*S+1, 0, 0, 1, 5'b00010};
    tab[5] = '{0, -1,  1, 0, 1, 5'b11110};
    tab[6] = '{1, 5*S-1, 0, 0, 1, 5'b00000};
    tab[7] = '{0, 5*S, 0, 0, 1, 5'b11110};
    tab[8] = '{3, -1,  1, 1, 0, 5'b00000};
    tab[9] = '{3, 13,  1, 0, 0, 5'b00000};

    #1;
    check("reset", pack_dut(), 15'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_idle", pack_dut(), 15'd0);

    for (int i = 0; i < 10; i++) run_seq(tab[i]);

    // abort while idle leaves the completed result untouched
    run_seq(tab[0]);
    for (int i = 0; i < 3; i++) begin
      abort = 1'b1;
      @(negedge clk);
      check("idle_abort", pack_dut(), {10'b0000010000, 5'b11110});
    end
    abort = 1'b0;

    // asynchronous reset in the middle of a sequence
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", {14'd0, busy}, 15'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", pack_dut(), 15'd0);
    @(negedge clk);
    check("rst_hold", pack_dut(), 15'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", pack_dut(), 15'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
